// File: rtl/mem_arb_pkg.sv
// Shared constants and port identifiers for the main_memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 16;

    typedef enum logic {
        PORT_IFETCH = 1'b0,
        PORT_LSU    = 1'b1
    } port_id_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way picker: round-robin against the last winner, or fixed priority to port 0.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    input  logic       fixed_prio,
    output logic [1:0] gnt_onehot
);

    always_comb begin
        gnt_onehot = 2'b00;
        case (req)
            2'b01: gnt_onehot = 2'b01;
            2'b10: gnt_onehot = 2'b10;
            2'b11: begin
                // On contention the port that did not win last time goes next.
                if (fixed_prio || (last_grant == PORT_LSU)) begin
                    gnt_onehot = 2'b01;
                end else begin
                    gnt_onehot = 2'b10;
                end
            end
            default: gnt_onehot = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port main_memory between instruction fetch (port 0) and
// the load/store unit (port 1); read data returns one cycle after the grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    port_id_t   last_grant;
    logic       rsp_valid;
    port_id_t   rsp_port;
    logic [1:0] pick;
    logic [1:0] gnt;
    logic       gnt_we;

    rr_pick2 u_pick (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt_onehot (pick)
    );

    // Grants are suppressed while reset is held so nothing reaches the memory.
    assign gnt    = pick & {2{reset_n}};
    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    always_comb begin
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        gnt_we         = 1'b0;
        if (gnt[0]) begin
            gnt_we    = p0_we;
            mem_write = p0_we;
            mem_addr  = p0_addr;
            if (p0_we) begin
                mem_write_data = p0_wdata;
            end
        end else if (gnt[1]) begin
            gnt_we    = p1_we;
            mem_write = p1_we;
            mem_addr  = p1_addr;
            if (p1_we) begin
                mem_write_data = p1_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PORT_LSU;
            rsp_valid  <= 1'b0;
            rsp_port   <= PORT_IFETCH;
        end else if (gnt != 2'b00) begin
            last_grant <= port_id_t'(gnt[1]);
            rsp_valid  <= ~gnt_we;
            rsp_port   <= port_id_t'(gnt[1]);
        end else begin
            rsp_valid  <= 1'b0;
        end
    end

    // The memory's output register already holds the data; steer it to the owner.
    assign p0_rvalid = rsp_valid && (rsp_port == PORT_IFETCH);
    assign p1_rvalid = rsp_valid && (rsp_port == PORT_LSU);
    assign p0_rdata  = p0_rvalid ? mem_read_data : '0;
    assign p1_rdata  = p1_rvalid ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data, mem_read_data;

    logic          b_p0_req, b_p0_we, b_p0_gnt, b_p0_rvalid;
    logic [AW-1:0] b_p0_addr;
    logic [DW-1:0] b_p0_wdata, b_p0_rdata;
    logic          b_p1_req, b_p1_we, b_p1_gnt, b_p1_rvalid;
    logic [AW-1:0] b_p1_addr;
    logic [DW-1:0] b_p1_wdata, b_p1_rdata;
    logic          b_mem_write;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_write_data, b_mem_read_data;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset_n(reset_n),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
        .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_write_data(b_mem_write_data),
        .mem_read_data(b_mem_read_data)
    );

    // Environment memories with a registered read port.
    logic [DW-1:0] ram  [32];
    logic [DW-1:0] ramb [32];
    always @(posedge clock) begin
        if (mem_write) ram[mem_addr] <= mem_write_data;
        mem_read_data <= ram[mem_addr];
        if (b_mem_write) ramb[b_mem_addr] <= b_mem_write_data;
        b_mem_read_data <= ramb[b_mem_addr];
    end

    // Reference model state: shadow memory, last winner, pending read response.
    logic [DW-1:0] ref_mem [32];
    int            m_last;
    bit            m_pv;
    int            m_pp;
    logic [DW-1:0] m_pd;
    int            g_cur;
    int            w0, w1;
    int            n_chk, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick();
        if (!reset_n) return -1;
        if (p0_req && p1_req) return (m_last == 0) ? 1 : 0;
        if (p0_req) return 0;
        if (p1_req) return 1;
        return -1;
    endfunction

    task automatic sample();
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clock);
        if (!reset_n) begin m_last = 1; m_pv = 0; end
        g_cur = pick();
        ew = 1'b0; ea = '0; ed = '0;
        if (g_cur == 0) begin
            ew = p0_we; ea = p0_addr; ed = p0_we ? p0_wdata : '0;
        end else if (g_cur == 1) begin
            ew = p1_we; ea = p1_addr; ed = p1_we ? p1_wdata : '0;
        end
        check("p0_gnt", p0_gnt, g_cur == 0);
        check("p1_gnt", p1_gnt, g_cur == 1);
        check("mem_write", mem_write, ew);
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_write_data, ed);
        check("p0_rvalid", p0_rvalid, m_pv && m_pp == 0);
        check("p1_rvalid", p1_rvalid, m_pv && m_pp == 1);
        check("p0_rdata", p0_rdata, (m_pv && m_pp == 0) ? m_pd : '0);
        check("p1_rdata", p1_rdata, (m_pv && m_pp == 1) ? m_pd : '0);
        if (reset_n && p0_req) begin
            w0 = p0_gnt ? 0 : w0 + 1;
            check("p0_wait", w0 <= 1, 1);
        end else w0 = 0;
        if (reset_n && p1_req) begin
            w1 = p1_gnt ? 0 : w1 + 1;
            check("p1_wait", w1 <= 1, 1);
        end else w1 = 0;
    endtask

    task automatic advance();
        @(posedge clock);
        if (!reset_n) begin
            m_last = 1; m_pv = 0;
        end else if (g_cur >= 0) begin
            logic          we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            we = (g_cur == 0) ? p0_we : p1_we;
            a  = (g_cur == 0) ? p0_addr : p1_addr;
            d  = (g_cur == 0) ? p0_wdata : p1_wdata;
            m_last = g_cur;
            m_pv   = !we;
            m_pp   = g_cur;
            if (we) ref_mem[a] = d;
            else    m_pd = ref_mem[a];
        end else begin
            m_pv = 0;
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic new_req(output logic r, output logic w, output logic [AW-1:0] a,
                           output logic [DW-1:0] d);
        r = ($urandom_range(0, 3) != 0);
        w = $urandom_range(0, 1) == 1;
        a = AW'($urandom_range(0, 31));
        d = DW'($urandom);
    endtask

    task automatic idle_ports();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    initial begin
        int gseq [4];
        int bad;
        n_chk = 0; n_fail = 0; w0 = 0; w1 = 0;
        m_last = 1; m_pv = 0; m_pp = 0; m_pd = '0; g_cur = -1;
        for (int i = 0; i < 32; i++) begin
            ram[i] = DW'($urandom); ref_mem[i] = ram[i];
            ramb[i] = 16'hA000 + 16'(i);
        end
        ram[3] = 16'hBEEF; ref_mem[3] = 16'hBEEF;
        b_p0_req = 0; b_p0_we = 0; b_p0_addr = '0; b_p0_wdata = '0;
        b_p1_req = 0; b_p1_we = 0; b_p1_addr = '0; b_p1_wdata = '0;

        // Reset held with live write requests: nothing may reach the memory.
        reset_n = 0;
        p0_req = 1; p0_we = 1; p0_addr = 5'd7; p0_wdata = 16'h5555;
        p1_req = 1; p1_we = 1; p1_addr = 5'd9; p1_wdata = 16'hAAAA;
        step(); step();
        idle_ports();
        reset_n = 1;

        // Contention from reset: both read continuously.
        p0_req = 1; p0_addr = 5'd5; p1_req = 1; p1_addr = 5'd6;
        for (int i = 0; i < 4; i++) begin
            sample();
            gseq[i] = p0_gnt ? 0 : (p1_gnt ? 1 : -1);
            advance();
        end
        for (int i = 0; i < 4; i++) check("rr_seq", gseq[i], i % 2);
        idle_ports();
        step();

        // Single read of the preloaded word.
        p0_req = 1; p0_we = 0; p0_addr = 5'd3;
        sample(); check("single_gnt", p0_gnt, 1); advance();
        p0_req = 0;
        sample();
        check("single_rvalid", p0_rvalid, 1);
        check("single_rdata", p0_rdata, 16'hBEEF);
        check("single_p1_rvalid", p1_rvalid, 0);
        advance();

        // Write on port 1 followed immediately by a read on port 0.
        p1_req = 1; p1_we = 1; p1_addr = 5'd31; p1_wdata = 16'h1234;
        step();
        idle_ports();
        p0_req = 1; p0_addr = 5'd31;
        sample();
        check("wr_no_rvalid0", p0_rvalid, 0);
        check("wr_no_rvalid1", p1_rvalid, 0);
        advance();
        p0_req = 0;
        sample();
        check("wr_rd_rvalid", p0_rvalid, 1);
        check("wr_rd_rdata", p0_rdata, 16'h1234);
        advance();

        // Randomized traffic; requests are held until granted.
        for (int c = 0; c < 400; c++) begin
            sample();
            advance();
            if (!p0_req || g_cur == 0) new_req(p0_req, p0_we, p0_addr, p0_wdata);
            if (!p1_req || g_cur == 1) new_req(p1_req, p1_we, p1_addr, p1_wdata);
        end
        idle_ports();
        step();

        // Reset lands between a port-1 read grant and the edge.
        p1_req = 1; p1_we = 0; p1_addr = 5'd9;
        sample();
        check("rst_p1_gnt", p1_gnt, 1);
        #2 reset_n = 0;
        advance();
        idle_ports();
        step();
        sample(); check("rst_p1_rvalid_held", p1_rvalid, 0); advance();
        reset_n = 1;
        sample(); check("rst_p1_rvalid_after", p1_rvalid, 0); advance();
        p0_req = 1; p0_addr = 5'd1; p1_req = 1; p1_addr = 5'd2;
        sample(); check("rst_first_win", p0_gnt, 1); advance();
        idle_ports();
        step();

        // Idle: memory must stay untouched.
        for (int i = 0; i < 10; i++) begin
            sample();
            check("idle_write", mem_write, 0);
            advance();
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("mem_contents", bad, 0);

        // Fixed-priority instance: port 0 always wins until it drops.
        b_p0_req = 1; b_p0_addr = 5'd1; b_p1_req = 1; b_p1_addr = 5'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("fp_p0_gnt", b_p0_gnt, 1);
            check("fp_p1_gnt", b_p1_gnt, 0);
            if (i > 0) begin
                check("fp_p0_rvalid", b_p0_rvalid, 1);
                check("fp_p0_rdata", b_p0_rdata, 16'hA001);
            end
            @(posedge clock); #1;
        end
        b_p0_req = 0;
        @(negedge clock);
        check("fp_p1_gnt_drop", b_p1_gnt, 1);
        check("fp_p0_gnt_drop", b_p0_gnt, 0);
        @(posedge clock); #1;
        b_p1_req = 0;
        @(negedge clock);
        check("fp_p1_rvalid", b_p1_rvalid, 1);
        check("fp_p1_rdata", b_p1_rdata, 16'hA002);
        check("fp_p0_rvalid_end", b_p0_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
